// File: rtl/pll_reset_sequencer.sv
// PLL reset/lock sequencer: pulses the PLL reset, waits for a synchronized lock,
// qualifies it for a stable window, then flags the clock ready; retries and latches failure.
module pll_reset_sequencer #(
  parameter int RST_PULSE_CYCLES    = 16,
  parameter int LOCK_TIMEOUT_CYCLES = 65536,
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int MAX_RETRIES         = 3,
  parameter int CNT_W               = 8
) (
  input  logic             refclk,
  input  logic             rst,
  input  logic             pll_locked,
  input  logic             relock_req,
  output logic             pll_rst,
  output logic             clk_ready,
  output logic             fail,
  output logic [CNT_W-1:0] retry_cnt,
  output logic [CNT_W-1:0] lock_lost_cnt,
  output logic [2:0]       state
);

  localparam int RST_W = (RST_PULSE_CYCLES    > 1) ? $clog2(RST_PULSE_CYCLES)    : 1;
  localparam int TMO_W = (LOCK_TIMEOUT_CYCLES > 1) ? $clog2(LOCK_TIMEOUT_CYCLES) : 1;
  localparam int STB_W = (LOCK_STABLE_CYCLES  > 1) ? $clog2(LOCK_STABLE_CYCLES)  : 1;
  localparam int MAX_W = (RST_W > TMO_W) ? RST_W : TMO_W;
  localparam int TMR_W = (MAX_W > STB_W) ? MAX_W : STB_W;

  localparam logic [TMR_W-1:0] RST_LAST  = TMR_W'(RST_PULSE_CYCLES - 1);
  localparam logic [TMR_W-1:0] TMO_LAST  = TMR_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [TMR_W-1:0] STB_LAST  = TMR_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] RETRY_MAX = CNT_W'(MAX_RETRIES);

  typedef enum logic [2:0] {
    S_RESET     = 3'd0,
    S_WAIT_LOCK = 3'd1,
    S_STABLE    = 3'd2,
    S_READY     = 3'd3,
    S_FAIL      = 3'd4
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [TMR_W-1:0] r_timer, w_timer_nxt;
  logic [CNT_W-1:0] r_retry, w_retry_nxt;
  logic [CNT_W-1:0] r_lost, w_lost_nxt;
  logic [CNT_W-1:0] w_retry_inc;
  logic             r_sync1, r_sync2;
  logic             w_locked_s;

  // pll_locked is asynchronous to refclk; only the second flop feeds decisions.
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= pll_locked;
      r_sync2 <= r_sync1;
    end
  end

  assign w_locked_s  = r_sync2;
  assign w_retry_inc = r_retry + CNT_W'(1);

  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      r_state <= S_RESET;
      r_timer <= '0;
      r_retry <= '0;
      r_lost  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_timer <= w_timer_nxt;
      r_retry <= w_retry_nxt;
      r_lost  <= w_lost_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_timer_nxt = r_timer;
    w_retry_nxt = r_retry;
    w_lost_nxt  = r_lost;
    case (r_state)
      S_RESET: begin
        if (r_timer == RST_LAST) begin
          w_state_nxt = S_WAIT_LOCK;
          w_timer_nxt = '0;
        end else begin
          w_timer_nxt = r_timer + TMR_W'(1);
        end
      end
      S_WAIT_LOCK: begin
        // Lock takes priority over a coincident timeout terminal count.
        if (relock_req) begin
          w_state_nxt = S_RESET;
          w_timer_nxt = '0;
          w_retry_nxt = '0;
        end else if (w_locked_s) begin
          w_state_nxt = S_STABLE;
          w_timer_nxt = '0;
        end else if (r_timer == TMO_LAST) begin
          w_retry_nxt = w_retry_inc;
          w_timer_nxt = '0;
          w_state_nxt = (w_retry_inc == RETRY_MAX) ? S_FAIL : S_RESET;
        end else begin
          w_timer_nxt = r_timer + TMR_W'(1);
        end
      end
      S_STABLE: begin
        if (relock_req) begin
          w_state_nxt = S_RESET;
          w_timer_nxt = '0;
          w_retry_nxt = '0;
        end else if (!w_locked_s) begin
          w_state_nxt = S_WAIT_LOCK;
          w_timer_nxt = '0;
        end else if (r_timer == STB_LAST) begin
          w_state_nxt = S_READY;
          w_timer_nxt = '0;
          w_retry_nxt = '0;
        end else begin
          w_timer_nxt = r_timer + TMR_W'(1);
        end
      end
      S_READY: begin
        // A software relock is not a lock-loss event, even if lock drops in the same cycle.
        if (relock_req) begin
          w_state_nxt = S_RESET;
          w_timer_nxt = '0;
          w_retry_nxt = '0;
        end else if (!w_locked_s) begin
          w_state_nxt = S_RESET;
          w_timer_nxt = '0;
          w_lost_nxt  = (&r_lost) ? r_lost : r_lost + CNT_W'(1);
        end
      end
      S_FAIL: begin
        if (relock_req) begin
          w_state_nxt = S_RESET;
          w_timer_nxt = '0;
          w_retry_nxt = '0;
        end
      end
      default: begin
        w_state_nxt = S_RESET;
        w_timer_nxt = '0;
      end
    endcase
  end

  assign pll_rst       = (r_state == S_RESET) || (r_state == S_FAIL);
  assign clk_ready     = (r_state == S_READY);
  assign fail          = (r_state == S_FAIL);
  assign retry_cnt     = r_retry;
  assign lock_lost_cnt = r_lost;
  assign state         = r_state;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Bench for pll_reset_sequencer: scenario tasks checked against a phase/elapsed-time
// reference model of the sequencer, plus direct timing measurements.
module tb_pll_reset_sequencer;

  localparam int RSTP = 4;
  localparam int TMO  = 32;
  localparam int STB  = 8;
  localparam int MAXR = 3;
  localparam int CW   = 8;
  localparam int LOST_SAT = (1 << CW) - 1;

  logic          refclk = 1'b0;
  logic          rst;
  logic          pll_locked;
  logic          relock_req;
  logic          pll_rst, clk_ready, fail;
  logic [CW-1:0] retry_cnt, lock_lost_cnt;
  logic [2:0]    state;

  int n_chk  = 0;
  int n_fail = 0;

  pll_reset_sequencer #(
    .RST_PULSE_CYCLES(RSTP), .LOCK_TIMEOUT_CYCLES(TMO), .LOCK_STABLE_CYCLES(STB),
    .MAX_RETRIES(MAXR), .CNT_W(CW)
  ) dut (
    .refclk(refclk), .rst(rst), .pll_locked(pll_locked), .relock_req(relock_req),
    .pll_rst(pll_rst), .clk_ready(clk_ready), .fail(fail),
    .retry_cnt(retry_cnt), .lock_lost_cnt(lock_lost_cnt), .state(state)
  );

  always #5 refclk = ~refclk;

  // Reference model: phase code, cycles elapsed in phase, and a 2-deep lock delay line.
  int   m_phase, m_el, m_retries, m_lost;
  logic m_p0, m_p1, m_lk;

  always @(posedge refclk or posedge rst) begin
    if (rst) begin
      m_phase = 0; m_el = 0; m_retries = 0; m_lost = 0; m_p0 = 1'b0; m_p1 = 1'b0;
    end else begin
      m_lk = m_p1;
      if (m_phase != 0 && relock_req) begin
        m_phase = 0; m_el = 0; m_retries = 0;
      end else begin
        case (m_phase)
          0: begin
            m_el++;
            if (m_el == RSTP) begin m_phase = 1; m_el = 0; end
          end
          1: begin
            if (m_lk) begin m_phase = 2; m_el = 0; end
            else begin
              m_el++;
              if (m_el == TMO) begin
                m_retries++; m_el = 0;
                m_phase = (m_retries == MAXR) ? 4 : 0;
              end
            end
          end
          2: begin
            if (!m_lk) begin m_phase = 1; m_el = 0; end
            else begin
              m_el++;
              if (m_el == STB) begin m_phase = 3; m_el = 0; m_retries = 0; end
            end
          end
          3: if (!m_lk) begin
            m_phase = 0; m_el = 0;
            if (m_lost < LOST_SAT) m_lost++;
          end
          default: ;
        endcase
      end
      m_p1 = m_p0;
      m_p0 = pll_locked;
    end
  end

  logic [21:0] dut_vec, exp_vec;
  assign dut_vec = {state, pll_rst, clk_ready, fail, retry_cnt, lock_lost_cnt};
  assign exp_vec = {3'(m_phase), (m_phase == 0 || m_phase == 4), (m_phase == 3), (m_phase == 4),
                    CW'(m_retries), CW'(m_lost)};

  task automatic tick();
    @(negedge refclk);
  endtask

  task automatic test_reset();
    rst = 1'b1; pll_locked = 1'b0; relock_req = 1'b0;
    repeat (3) tick();
    n_chk++;
    if (dut_vec !== {3'd0, 1'b1, 1'b0, 1'b0, 8'd0, 8'd0}) begin
      n_fail++; $display("FAIL reset_values: dut %h required %h", dut_vec, {3'd0, 1'b1, 1'b0, 1'b0, 8'd0, 8'd0});
    end
    n_chk++;
    if (dut_vec !== exp_vec) begin n_fail++; $display("FAIL reset_model: dut %h model %h", dut_vec, exp_vec); end
  endtask

  task automatic test_first_lock();
    int hi = 0;
    int n  = 0;
    rst = 1'b0;
    while (pll_rst === 1'b1 && hi < 20) begin
      hi++; tick();
      n_chk++;
      if (dut_vec !== exp_vec) begin n_fail++; $display("FAIL first_lock_model: dut %h model %h", dut_vec, exp_vec); end
    end
    n_chk++;
    if (hi != RSTP) begin n_fail++; $display("FAIL first_pulse_width: got %0d required %0d", hi, RSTP); end
    repeat (10) begin
      tick();
      n_chk++;
      if (dut_vec !== exp_vec) begin n_fail++; $display("FAIL first_wait_model: dut %h model %h", dut_vec, exp_vec); end
    end
    pll_locked = 1'b1;
    while (clk_ready !== 1'b1 && n < 40) begin
      tick(); n++;
      n_chk++;
      if (dut_vec !== exp_vec) begin n_fail++; $display("FAIL first_stable_model: dut %h model %h", dut_vec, exp_vec); end
    end
    // Edges after the sampling edge: 2 to cross the synchronizer, then STB in the stable window.
    n_chk++;
    if (n - 1 != 2 + STB) begin n_fail++; $display("FAIL first_ready_latency: got %0d required %0d", n - 1, 2 + STB); end
    n_chk++;
    if (retry_cnt !== 8'd0) begin n_fail++; $display("FAIL first_retry: got %0d required 0", retry_cnt); end
  endtask

  task automatic test_timeout_fail();
    logic [7:0] exp_q[$];
    int         got_q[$];
    logic       prev;
    int         run;
    rst = 1'b1; pll_locked = 1'b0; tick(); rst = 1'b0;
    for (int i = 0; i < MAXR; i++) begin exp_q.push_back(8'(RSTP)); exp_q.push_back(8'(TMO)); end
    prev = 1'b1; run = 1;
    for (int i = 0; i < 400 && fail !== 1'b1; i++) begin
      tick();
      n_chk++;
      if (dut_vec !== exp_vec) begin n_fail++; $display("FAIL timeout_model: dut %h model %h", dut_vec, exp_vec); end
      if (pll_rst === prev) run++;
      else begin got_q.push_back(run); prev = pll_rst; run = 1; end
    end
    n_chk++;
    if (got_q.size() != exp_q.size()) begin
      n_fail++; $display("FAIL timeout_run_count: got %0d required %0d", got_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      logic [7:0] e;
      int g;
      e = exp_q.pop_front(); g = got_q.pop_front();
      n_chk++;
      if (g != int'(e)) begin n_fail++; $display("FAIL timeout_run_len: got %0d required %0d", g, e); end
    end
    repeat (5) tick();
    n_chk++;
    if (dut_vec !== {3'd4, 1'b1, 1'b0, 1'b1, 8'd3, 8'd0}) begin
      n_fail++; $display("FAIL fail_hold: dut %h required %h", dut_vec, {3'd4, 1'b1, 1'b0, 1'b1, 8'd3, 8'd0});
    end
    relock_req = 1'b1; tick(); relock_req = 1'b0;
    n_chk++;
    if (dut_vec !== {3'd0, 1'b1, 1'b0, 1'b0, 8'd0, 8'd0}) begin
      n_fail++; $display("FAIL fail_relock: dut %h required %h", dut_vec, {3'd0, 1'b1, 1'b0, 1'b0, 8'd0, 8'd0});
    end
    n_chk++;
    if (dut_vec !== exp_vec) begin n_fail++; $display("FAIL fail_relock_model: dut %h model %h", dut_vec, exp_vec); end
  endtask

  task automatic test_stable_glitch();
    int   k;
    logic saw_wait = 1'b0;
    logic saw_ready = 1'b0;
    int   n = 0;
    for (int i = 0; i < 80 && !(retry_cnt === 8'd1 && state === 3'd1); i++) begin
      tick();
      n_chk++;
      if (dut_vec !== exp_vec) begin n_fail++; $display("FAIL glitch_pre_model: dut %h model %h", dut_vec, exp_vec); end
    end
    pll_locked = 1'b1;
    for (int i = 0; i < 10 && state !== 3'd2; i++) begin
      tick();
      n_chk++;
      if (dut_vec !== exp_vec) begin n_fail++; $display("FAIL glitch_lock_model: dut %h model %h", dut_vec, exp_vec); end
    end
    n_chk++;
    if (state !== 3'd2) begin n_fail++; $display("FAIL glitch_reach_stable: got %0d required 2", state); end
    k = $urandom_range(0, 4);
    repeat (k) tick();
    pll_locked = 1'b0; tick(); pll_locked = 1'b1;
    repeat (6) begin
      tick();
      if (state === 3'd1) saw_wait = 1'b1;
      if (clk_ready === 1'b1) saw_ready = 1'b1;
      n_chk++;
      if (dut_vec !== exp_vec) begin n_fail++; $display("FAIL glitch_model: dut %h model %h", dut_vec, exp_vec); end
    end
    n_chk++;
    if (!(saw_wait && !saw_ready && retry_cnt === 8'd1)) begin
      n_fail++; $display("FAIL glitch_effect: saw_wait %0b saw_ready %0b retry %0d required 1 0 1", saw_wait, saw_ready, retry_cnt);
    end
    while (clk_ready !== 1'b1 && n < 20) begin
      tick(); n++;
      n_chk++;
      if (dut_vec !== exp_vec) begin n_fail++; $display("FAIL glitch_relock_model: dut %h model %h", dut_vec, exp_vec); end
    end
    n_chk++;
    if (!(clk_ready === 1'b1 && retry_cnt === 8'd0)) begin
      n_fail++; $display("FAIL glitch_ready: clk_ready %0b retry %0d required 1 0", clk_ready, retry_cnt);
    end
  endtask

  task automatic test_lock_loss();
    int hi = 1;
    int n = 0;
    pll_locked = 1'b0;
    // Sampling edge, then two synchronizer edges before the FSM reacts.
    repeat (2) begin
      tick();
      n_chk++;
      if (clk_ready !== 1'b1) begin n_fail++; $display("FAIL loss_early_drop: clk_ready %0b required 1", clk_ready); end
    end
    tick();
    n_chk++;
    if (!(clk_ready === 1'b0 && pll_rst === 1'b1 && lock_lost_cnt === 8'd1)) begin
      n_fail++; $display("FAIL loss_react: clk_ready %0b pll_rst %0b lost %0d required 0 1 1", clk_ready, pll_rst, lock_lost_cnt);
    end
    pll_locked = 1'b1;
    while (pll_rst === 1'b1 && hi < 20) begin
      tick();
      if (pll_rst === 1'b1) hi++;
      n_chk++;
      if (dut_vec !== exp_vec) begin n_fail++; $display("FAIL loss_model: dut %h model %h", dut_vec, exp_vec); end
    end
    n_chk++;
    if (hi != RSTP) begin n_fail++; $display("FAIL loss_pulse_width: got %0d required %0d", hi, RSTP); end
    while (clk_ready !== 1'b1 && n < 30) begin
      tick(); n++;
      n_chk++;
      if (dut_vec !== exp_vec) begin n_fail++; $display("FAIL loss_relock_model: dut %h model %h", dut_vec, exp_vec); end
    end
    n_chk++;
    if (!(clk_ready === 1'b1 && lock_lost_cnt === 8'd1)) begin
      n_fail++; $display("FAIL loss_relocked: clk_ready %0b lost %0d required 1 1", clk_ready, lock_lost_cnt);
    end
  endtask

  task automatic test_lost_saturate();
    int exp_lost;
    rst = 1'b1; pll_locked = 1'b1; tick(); rst = 1'b0;
    for (int i = 0; i < 40 && clk_ready !== 1'b1; i++) begin
      tick();
      n_chk++;
      if (dut_vec !== exp_vec) begin n_fail++; $display("FAIL sat_start_model: dut %h model %h", dut_vec, exp_vec); end
    end
    // Lock loss and relock request land on the same FSM edge.
    pll_locked = 1'b0; tick(); tick(); relock_req = 1'b1; tick(); relock_req = 1'b0;
    n_chk++;
    if (!(state === 3'd0 && lock_lost_cnt === 8'd0)) begin
      n_fail++; $display("FAIL coincident_relock: state %0d lost %0d required 0 0", state, lock_lost_cnt);
    end
    pll_locked = 1'b1;
    for (int ev = 1; ev <= 256; ev++) begin
      for (int i = 0; i < 60 && clk_ready !== 1'b1; i++) begin
        tick();
        n_chk++;
        if (dut_vec !== exp_vec) begin n_fail++; $display("FAIL sat_model: dut %h model %h", dut_vec, exp_vec); end
      end
      pll_locked = 1'b0;
      for (int i = 0; i < 10 && pll_rst !== 1'b1; i++) tick();
      exp_lost = (ev < LOST_SAT) ? ev : LOST_SAT;
      n_chk++;
      if (lock_lost_cnt !== CW'(exp_lost)) begin
        n_fail++; $display("FAIL sat_count ev %0d: got %0d required %0d", ev, lock_lost_cnt, exp_lost);
      end
      repeat ($urandom_range(0, 3)) tick();
      pll_locked = 1'b1;
    end
  endtask

  task automatic test_async_reset();
    rst = 1'b1; pll_locked = 1'b1; tick(); rst = 1'b0;
    repeat (2) begin
      for (int i = 0; i < 40 && clk_ready !== 1'b1; i++) tick();
      pll_locked = 1'b0;
      for (int i = 0; i < 10 && pll_rst !== 1'b1; i++) tick();
      pll_locked = 1'b1;
    end
    pll_locked = 1'b0;
    for (int i = 0; i < 100 && !(retry_cnt === 8'd1 && state === 3'd1); i++) begin
      tick();
      n_chk++;
      if (dut_vec !== exp_vec) begin n_fail++; $display("FAIL async_pre_model: dut %h model %h", dut_vec, exp_vec); end
    end
    repeat ($urandom_range(1, 10)) tick();
    n_chk++;
    if (!(state === 3'd1 && lock_lost_cnt === 8'd2 && retry_cnt === 8'd1)) begin
      n_fail++; $display("FAIL async_setup: state %0d lost %0d retry %0d required 1 2 1", state, lock_lost_cnt, retry_cnt);
    end
    #2 rst = 1'b1;
    #1;
    n_chk++;
    if (dut_vec !== {3'd0, 1'b1, 1'b0, 1'b0, 8'd0, 8'd0}) begin
      n_fail++; $display("FAIL async_reset: dut %h required %h", dut_vec, {3'd0, 1'b1, 1'b0, 1'b0, 8'd0, 8'd0});
    end
    n_chk++;
    if (dut_vec !== exp_vec) begin n_fail++; $display("FAIL async_reset_model: dut %h model %h", dut_vec, exp_vec); end
    tick(); rst = 1'b0; tick();
  endtask

  initial begin
    rst = 1'b1; pll_locked = 1'b0; relock_req = 1'b0;
    test_reset();
    test_first_lock();
    test_timeout_fail();
    test_stable_glitch();
    test_lock_loss();
    test_lost_saturate();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
